// File: rtl/register_file_bank_if.sv
// Write-port and dual read-port bundle for register_file_bank.
// Carries no state of its own; timing is defined by the attached register file.
// No backpressure: the master may present one write and two reads every cycle.
interface register_file_bank_if #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_COUNT  = 8,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT)
);
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [ADDR_WIDTH-1:0] read_address_a;
    logic [ADDR_WIDTH-1:0] read_address_b;
    logic [DATA_WIDTH-1:0] read_data_a;
    logic [DATA_WIDTH-1:0] read_data_b;
    logic [REG_COUNT-1:0]  written_mask;
    logic                  write_error;

    // Datapath side that issues write-back and operand reads.
    modport master (
        output write_enable, write_address, write_data,
        output read_address_a, read_address_b,
        input  read_data_a, read_data_b, written_mask, write_error
    );

    // Register file side.
    modport slave (
        input  write_enable, write_address, write_data,
        input  read_address_a, read_address_b,
        output read_data_a, read_data_b, written_mask, write_error
    );
endinterface

// File: rtl/register_file_bank.sv
// General-purpose register file: one write port, two registered read ports, write-first forwarding.
// Read latency 1 cycle (forwarded or not); writes land at the sampling edge; write_error follows a bad write by one edge.
// Never stalls: one write and two reads are accepted every cycle, no backpressure.
module register_file_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_COUNT  = 8,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT),
    parameter bit ZERO_REG   = 1'b0
) (
    input  logic                   wire_clock,
    input  logic                   wire_reset_n,
    register_file_bank_if.slave    bus
);
    localparam int ADDR_SPAN = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [REG_COUNT-1:0]  mask_q;
    logic [DATA_WIDTH-1:0] rd_a_q, rd_a_d;
    logic [DATA_WIDTH-1:0] rd_b_q, rd_b_d;
    logic                  err_q, err_d;

    logic wr_in_range;
    logic wr_to_zero;
    logic wr_accept;

    // Every address is legal when the count fills the whole address space.
    generate
        if (REG_COUNT >= ADDR_SPAN) begin : g_full_range
            assign wr_in_range = 1'b1;
        end else begin : g_partial_range
            assign wr_in_range = (bus.write_address < ADDR_WIDTH'(REG_COUNT));
        end
    endgenerate

    // Writes to the hard-wired zero register are dropped without raising an error.
    assign wr_to_zero = ZERO_REG && (bus.write_address == '0);
    assign wr_accept  = bus.write_enable && wr_in_range && !wr_to_zero;
    assign err_d      = bus.write_enable && !wr_in_range;

    // Read muxes: out-of-range addresses match no register and fall through to 0;
    // an accepted write to the same address wins over the stored value.
    always_comb begin
        rd_a_d = '0;
        rd_b_d = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (bus.read_address_a == ADDR_WIDTH'(i)) begin
                rd_a_d = regs_q[i];
            end
            if (bus.read_address_b == ADDR_WIDTH'(i)) begin
                rd_b_d = regs_q[i];
            end
        end
        if (wr_accept && (bus.read_address_a == bus.write_address)) begin
            rd_a_d = bus.write_data;
        end
        if (wr_accept && (bus.read_address_b == bus.write_address)) begin
            rd_b_d = bus.write_data;
        end
    end

    // Register array and written-since-reset mask; register 0 stays 0 under ZERO_REG
    // because accepted writes never target it.
    always_ff @(posedge wire_clock or negedge wire_reset_n) begin
        if (!wire_reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            mask_q <= '0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (wr_accept && (bus.write_address == ADDR_WIDTH'(i))) begin
                    regs_q[i] <= bus.write_data;
                    mask_q[i] <= 1'b1;
                end
            end
        end
    end

    // Registered read ports and the one-cycle error pulse.
    always_ff @(posedge wire_clock or negedge wire_reset_n) begin
        if (!wire_reset_n) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
            err_q  <= 1'b0;
        end else begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
            err_q  <= err_d;
        end
    end

    assign bus.read_data_a  = rd_a_q;
    assign bus.read_data_b  = rd_b_q;
    assign bus.written_mask = mask_q;
    assign bus.write_error  = err_q;
endmodule

// File: tb/tb_register_file_bank.sv
// Bench for register_file_bank: three instances (8 regs, 8 regs with zero register, 6 regs)
// share one stimulus stream and are checked against a behavioural model of the register file.
// Directed scenarios first, then a randomized stream.
module tb_register_file_bank;
    logic wire_clock   = 1'b0;
    logic wire_reset_n = 1'b0;
    always #5 wire_clock = ~wire_clock;

    logic        we_s = 1'b0;
    logic [2:0]  wa_s = '0;
    logic [2:0]  ra_s = '0;
    logic [2:0]  rb_s = '0;
    logic [15:0] wd_s = '0;

    register_file_bank_if #(.DATA_WIDTH(16), .REG_COUNT(8), .ADDR_WIDTH(3)) bus0 ();
    register_file_bank_if #(.DATA_WIDTH(16), .REG_COUNT(8), .ADDR_WIDTH(3)) bus1 ();
    register_file_bank_if #(.DATA_WIDTH(16), .REG_COUNT(6), .ADDR_WIDTH(3)) bus2 ();

    register_file_bank #(.DATA_WIDTH(16), .REG_COUNT(8), .ADDR_WIDTH(3), .ZERO_REG(1'b0)) u_dut0 (
        .wire_clock(wire_clock), .wire_reset_n(wire_reset_n), .bus(bus0));
    register_file_bank #(.DATA_WIDTH(16), .REG_COUNT(8), .ADDR_WIDTH(3), .ZERO_REG(1'b1)) u_dut1 (
        .wire_clock(wire_clock), .wire_reset_n(wire_reset_n), .bus(bus1));
    register_file_bank #(.DATA_WIDTH(16), .REG_COUNT(6), .ADDR_WIDTH(3), .ZERO_REG(1'b0)) u_dut2 (
        .wire_clock(wire_clock), .wire_reset_n(wire_reset_n), .bus(bus2));

    assign bus0.write_enable = we_s;  assign bus0.write_address = wa_s;  assign bus0.write_data = wd_s;
    assign bus0.read_address_a = ra_s; assign bus0.read_address_b = rb_s;
    assign bus1.write_enable = we_s;  assign bus1.write_address = wa_s;  assign bus1.write_data = wd_s;
    assign bus1.read_address_a = ra_s; assign bus1.read_address_b = rb_s;
    assign bus2.write_enable = we_s;  assign bus2.write_address = wa_s;  assign bus2.write_data = wd_s;
    assign bus2.read_address_a = ra_s; assign bus2.read_address_b = rb_s;

    logic [15:0] obs_a    [3];
    logic [15:0] obs_b    [3];
    logic [7:0]  obs_mask [3];
    logic        obs_err  [3];
    assign obs_a[0] = bus0.read_data_a; assign obs_b[0] = bus0.read_data_b;
    assign obs_a[1] = bus1.read_data_a; assign obs_b[1] = bus1.read_data_b;
    assign obs_a[2] = bus2.read_data_a; assign obs_b[2] = bus2.read_data_b;
    assign obs_mask[0] = bus0.written_mask;
    assign obs_mask[1] = bus1.written_mask;
    assign obs_mask[2] = {2'b00, bus2.written_mask};
    assign obs_err[0] = bus0.write_error;
    assign obs_err[1] = bus1.write_error;
    assign obs_err[2] = bus2.write_error;

    // Behavioural model: register contents, written set and expected outputs per instance.
    logic [15:0] m_reg  [3][8];
    logic [7:0]  m_mask [3];
    logic [15:0] exp_a  [3];
    logic [15:0] exp_b  [3];
    logic        exp_err[3];

    int checks = 0;
    int errors = 0;

    function automatic int reg_count(input int c);
        return (c == 2) ? 6 : 8;
    endfunction

    function automatic bit has_zero(input int c);
        return (c == 1);
    endfunction

    function automatic logic [15:0] model_read(input int c, input int addr, input bit acc,
                                               input int wa, input logic [15:0] wd);
        if (addr >= reg_count(c)) return 16'h0000;
        if (has_zero(c) && addr == 0) return 16'h0000;
        if (acc && addr == wa) return wd;
        return m_reg[c][addr];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 8; i++) m_reg[c][i] = 16'h0000;
            m_mask[c]  = 8'h00;
            exp_a[c]   = 16'h0000;
            exp_b[c]   = 16'h0000;
            exp_err[c] = 1'b0;
        end
    endtask

    // One clock of stimulus; returns 1 time unit after the edge with the model advanced.
    task automatic step(input bit we, input int wa, input logic [15:0] wd, input int ra, input int rb);
        bit acc;
        @(negedge wire_clock);
        we_s = we; wa_s = 3'(wa); wd_s = wd; ra_s = 3'(ra); rb_s = 3'(rb);
        @(posedge wire_clock);
        for (int c = 0; c < 3; c++) begin
            acc        = we && (wa < reg_count(c)) && !(has_zero(c) && wa == 0);
            exp_err[c] = we && (wa >= reg_count(c));
            exp_a[c]   = model_read(c, ra, acc, wa, wd);
            exp_b[c]   = model_read(c, rb, acc, wa, wd);
            if (acc) begin
                m_reg[c][wa]  = wd;
                m_mask[c][wa] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        wire_reset_n = 1'b0;
        model_reset();
        repeat (4) begin
            @(negedge wire_clock);
            we_s = 1'b1; wa_s = 3'($urandom_range(0, 7)); wd_s = 16'($urandom);
            ra_s = 3'($urandom_range(0, 7)); rb_s = 3'($urandom_range(0, 7));
            @(posedge wire_clock);
            #1;
            for (int c = 0; c < 3; c++) begin
                checks++;
                if ({obs_a[c], obs_b[c], obs_mask[c], obs_err[c]} !== 41'h0) begin
                    errors++;
                    $display("FAIL reset_hold cfg%0d: a=%h b=%h mask=%h err=%b, required all 0",
                             c, obs_a[c], obs_b[c], obs_mask[c], obs_err[c]);
                end
            end
        end
        @(negedge wire_clock);
        we_s = 1'b0;
        wire_reset_n = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({obs_a[c], obs_b[c], obs_mask[c], obs_err[c]} !== 41'h0) begin
                errors++;
                $display("FAIL reset_release cfg%0d: a=%h b=%h mask=%h err=%b, required all 0",
                         c, obs_a[c], obs_b[c], obs_mask[c], obs_err[c]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 0, 16'h0, i, 7 - i);
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (obs_a[c] !== 16'h0 || obs_b[c] !== 16'h0) begin
                    errors++;
                    $display("FAIL reset_read cfg%0d addr %0d: a=%h b=%h, required 0 0",
                             c, i, obs_a[c], obs_b[c]);
                end
            end
        end
    endtask

    task automatic test_basic();
        step(1'b1, 3, 16'h1234, 0, 1);
        step(1'b0, 0, 16'h0, 3, 3);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs_a[c] !== 16'h1234 || obs_b[c] !== 16'h1234 || obs_mask[c] !== 8'b0000_1000) begin
                errors++;
                $display("FAIL basic_rw cfg%0d: a=%h b=%h mask=%b, required 1234 1234 00001000",
                         c, obs_a[c], obs_b[c], obs_mask[c]);
            end
        end
    endtask

    task automatic test_forwarding();
        logic [15:0] v4;
        v4 = 16'($urandom);
        step(1'b1, 5, 16'h00AA, 0, 0);
        step(1'b1, 4, v4, 0, 0);
        step(1'b1, 5, 16'hBEEF, 5, 4);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs_a[c] !== 16'hBEEF || obs_b[c] !== v4) begin
                errors++;
                $display("FAIL forward cfg%0d: a=%h b=%h, required beef %h", c, obs_a[c], obs_b[c], v4);
            end
        end
        step(1'b0, 0, 16'h0, 5, 5);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs_a[c] !== 16'hBEEF || obs_b[c] !== 16'hBEEF) begin
                errors++;
                $display("FAIL forward_stored cfg%0d: a=%h b=%h, required beef beef", c, obs_a[c], obs_b[c]);
            end
        end
    endtask

    task automatic test_zero_reg();
        step(1'b1, 0, 16'hFFFF, 0, 0);
        checks++;
        if (obs_a[1] !== 16'h0 || obs_mask[1][0] !== 1'b0 || obs_err[1] !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg_write: a=%h mask0=%b err=%b, required 0 0 0",
                     obs_a[1], obs_mask[1][0], obs_err[1]);
        end
        checks++;
        if (obs_a[0] !== 16'hFFFF || obs_mask[0][0] !== 1'b1) begin
            errors++;
            $display("FAIL plain_reg0_write: a=%h mask0=%b, required ffff 1", obs_a[0], obs_mask[0][0]);
        end
        step(1'b0, 0, 16'h0, 0, 0);
        checks++;
        if (obs_a[1] !== 16'h0 || obs_b[1] !== 16'h0 || obs_a[0] !== 16'hFFFF) begin
            errors++;
            $display("FAIL zero_reg_read: zr_a=%h zr_b=%h plain_a=%h, required 0 0 ffff",
                     obs_a[1], obs_b[1], obs_a[0]);
        end
    endtask

    task automatic test_out_of_range();
        step(1'b1, 7, 16'h5555, 7, 7);
        checks++;
        if (obs_err[2] !== 1'b1 || obs_a[2] !== 16'h0 || obs_mask[2] !== m_mask[2] || obs_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL oor_write: err=%b a=%h mask=%h plain_err=%b, required 1 0 %h 0",
                     obs_err[2], obs_a[2], obs_mask[2], obs_err[0], m_mask[2]);
        end
        step(1'b0, 0, 16'h0, 7, 6);
        checks++;
        if (obs_err[2] !== 1'b0 || obs_a[2] !== 16'h0 || obs_b[2] !== 16'h0 || obs_a[0] !== 16'h5555) begin
            errors++;
            $display("FAIL oor_after: err=%b a=%h b=%h plain_a=%h, required 0 0 0 5555",
                     obs_err[2], obs_a[2], obs_b[2], obs_a[0]);
        end
        step(1'b1, 6, 16'h1111, 0, 0);
        step(1'b1, 7, 16'h2222, 0, 0);
        checks++;
        if (obs_err[2] !== 1'b1) begin
            errors++;
            $display("FAIL oor_back_to_back: err=%b, required 1", obs_err[2]);
        end
        step(1'b0, 0, 16'h0, 0, 0);
        checks++;
        if (obs_err[2] !== 1'b0 || obs_mask[2] !== m_mask[2]) begin
            errors++;
            $display("FAIL oor_clear: err=%b mask=%h, required 0 %h", obs_err[2], obs_mask[2], m_mask[2]);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 0, 16'h0, i, 5 - i);
            checks++;
            if (obs_a[2] !== exp_a[2] || obs_b[2] !== exp_b[2]) begin
                errors++;
                $display("FAIL oor_contents addr %0d: a=%h b=%h, required %h %h",
                         i, obs_a[2], obs_b[2], exp_a[2], exp_b[2]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7), 16'($urandom),
                 $urandom_range(0, 7), $urandom_range(0, 7));
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (obs_a[c] !== exp_a[c] || obs_b[c] !== exp_b[c] ||
                    obs_mask[c] !== m_mask[c] || obs_err[c] !== exp_err[c]) begin
                    errors++;
                    $display("FAIL random cfg%0d cycle %0d: a=%h b=%h mask=%h err=%b, required %h %h %h %b",
                             c, n, obs_a[c], obs_b[c], obs_mask[c], obs_err[c],
                             exp_a[c], exp_b[c], m_mask[c], exp_err[c]);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 8; i++) step(1'b1, i, 16'(16'h0101 * i), i, 7 - i);
        step(1'b0, 0, 16'h0, 7, 6);
        checks++;
        if (obs_a[0] !== 16'h0707 || obs_b[0] !== 16'h0606 || obs_mask[0] !== 8'hFF) begin
            errors++;
            $display("FAIL fill: a=%h b=%h mask=%h, required 0707 0606 ff", obs_a[0], obs_b[0], obs_mask[0]);
        end
        @(negedge wire_clock);
        we_s = 1'b1; wa_s = 3'd2; wd_s = 16'hDEAD; ra_s = 3'd2; rb_s = 3'd3;
        #2;
        wire_reset_n = 1'b0;
        model_reset();
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({obs_a[c], obs_b[c], obs_mask[c], obs_err[c]} !== 41'h0) begin
                errors++;
                $display("FAIL async_reset cfg%0d: a=%h b=%h mask=%h err=%b, required all 0",
                         c, obs_a[c], obs_b[c], obs_mask[c], obs_err[c]);
            end
        end
        @(posedge wire_clock);
        #1;
        checks++;
        if (obs_a[0] !== 16'h0 || obs_mask[0] !== 8'h00) begin
            errors++;
            $display("FAIL reset_inflight: a=%h mask=%h, required 0 0", obs_a[0], obs_mask[0]);
        end
        @(negedge wire_clock);
        we_s = 1'b0;
        wire_reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 0, 16'h0, i, i);
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (obs_a[c] !== 16'h0 || obs_b[c] !== 16'h0 || obs_mask[c] !== 8'h00) begin
                    errors++;
                    $display("FAIL post_reset_read cfg%0d addr %0d: a=%h b=%h mask=%h, required 0 0 0",
                             c, i, obs_a[c], obs_b[c], obs_mask[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forwarding();
        test_zero_reg();
        test_out_of_range();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
